// File: rtl/exe_muldiv_unit.sv
// EXE-stage multiply/divide engine: signed/unsigned MULT/DIV producing a 64-bit {HI,LO} result.
// Latency: MUL result (MD_Done) at cycle MUL_LAT+1, DIV result at cycle 33 after acceptance.
// Backpressure: MD_Busy stalls the pipeline while computing; result held with MD_Done until EXE_Advance.
module exe_muldiv_unit #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_Flush,
    input  logic        EXE_Start,
    input  logic [1:0]  EXE_MDOp,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    input  logic        EXE_Advance,
    output logic        MD_Busy,
    output logic        MD_Done,
    output logic [31:0] MD_Hi,
    output logic [31:0] MD_Lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    // control state
    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;
    logic [4:0]  r_cnt;
    logic        r_done;

    // operands latched at acceptance; magnitudes feed the divider
    logic        r_signed;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_in_signed;
    logic [31:0] w_in_amag;
    logic [31:0] w_in_bmag;
    logic        w_mul_last;
    logic        w_div_last;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;

    // A flush cancels any acceptance in the same cycle, so it also drops the stall request.
    assign w_accept    = (r_state == S_IDLE) & EXE_Start & ~EXE_Flush;
    assign MD_Busy     = (r_state == S_MUL) | (r_state == S_DIV) | w_accept;
    assign MD_Done     = r_done;
    assign MD_Hi       = r_hi;
    assign MD_Lo       = r_lo;

    assign w_in_signed = ~EXE_MDOp[0];
    assign w_in_amag   = (w_in_signed & EXE_BusA[31]) ? (32'd0 - EXE_BusA) : EXE_BusA;
    assign w_in_bmag   = (w_in_signed & EXE_BusB[31]) ? (32'd0 - EXE_BusB) : EXE_BusB;

    assign w_mul_last  = (r_cnt == MUL_LAST);
    assign w_div_last  = (r_cnt == DIV_LAST);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod = r_signed ? ({{32{r_opa[31]}}, r_opa} * {{32{r_opb[31]}}, r_opb})
                             : ({32'd0, r_opa} * {32'd0, r_opb});

    // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[32];
    assign w_rem_nx = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_nx = {r_quo[30:0], w_ge};

    // Sign fix on the final step; 0x80000000 / -1 wraps naturally back to 0x80000000.
    assign w_q_fix  = (r_signed & (r_opa[31] ^ r_opb[31])) ? (32'd0 - w_quo_nx) : w_quo_nx;
    assign w_r_fix  = (r_signed & r_opa[31]) ? (32'd0 - w_rem_nx) : w_rem_nx;
    assign w_div_hi = (r_opb == 32'd0) ? r_opa : w_r_fix;
    assign w_div_lo = (r_opb == 32'd0) ? 32'hFFFF_FFFF : w_q_fix;

    // Next-state selection; flush overrides every other request.
    always_comb begin
        w_state_nx = r_state;
        if (EXE_Flush) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (EXE_Start)   w_state_nx = EXE_MDOp[1] ? S_DIV : S_MUL;
                S_MUL:   if (w_mul_last)  w_state_nx = S_DONE;
                S_DIV:   if (w_div_last)  w_state_nx = S_DONE;
                S_DONE:  if (EXE_Advance) w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // State, iteration counter (restarts on every state change) and registered done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= (w_state_nx == S_DONE);
            if (EXE_Flush || (w_state_nx != r_state)) begin
                r_cnt <= 5'd0;
            end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Operand capture, divider iteration and result write-back; flush leaves HI/LO untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_signed <= 1'b0;
            r_opa    <= 32'd0;
            r_opb    <= 32'd0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_dvs    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            if (w_accept) begin
                r_signed <= w_in_signed;
                r_opa    <= EXE_BusA;
                r_opb    <= EXE_BusB;
                r_quo    <= w_in_amag;
                r_dvs    <= w_in_bmag;
                r_rem    <= 32'd0;
            end else if (!EXE_Flush && (r_state == S_DIV)) begin
                r_quo <= w_quo_nx;
                r_rem <= w_rem_nx;
            end

            if (!EXE_Flush && (r_state == S_MUL) && w_mul_last) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end else if (!EXE_Flush && (r_state == S_DIV) && w_div_last) begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end
        end
    end

endmodule
